// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry {pc, inst} FIFO between fetch and decode with mispredict flush and recovery stall.
// Optional macro FETCH_QUEUE_BYPASS_EN adds a 0-cycle combinational path through an empty queue.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_pc,
  input  logic [31:0]   in_inst,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_inst,
  input  logic          flush,
  input  logic          stall,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_CNT = CW'(0);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   pc_d   [DEPTH];
  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   inst_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic empty_s, full_s, bypass_s, push_s, wr_en_s, pop_s;

  // Handshake, head presentation and bypass selection
  always_comb begin
    empty_s = (count_q == ZERO_CNT);
    full_s  = (count_q == FULL_CNT);
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass_s = empty_s && in_valid && out_ready && !flush && !stall;
`else
    bypass_s = 1'b0;
`endif
    // A full queue refuses input even when it pops this cycle
    in_ready  = !full_s && !flush;
    out_valid = (!empty_s && !flush && !stall) || bypass_s;
    if (bypass_s) begin
      out_pc   = in_pc;
      out_inst = in_inst;
    end else begin
      out_pc   = pc_q[head_q];
      out_inst = inst_q[head_q];
    end
    push_s  = in_valid && in_ready;
    wr_en_s = push_s && !bypass_s;
    pop_s   = out_valid && out_ready && !empty_s;
    count   = count_q;
  end

  // Next-state: flush empties pointers/count but leaves stored data alone
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = {PW{1'b0}};
      tail_d  = {PW{1'b0}};
      count_d = ZERO_CNT;
    end else begin
      if (wr_en_s) begin
        pc_d[tail_q]   = in_pc;
        inst_d[tail_q] = in_inst;
        tail_d         = tail_q + PTR_ONE;
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_d = count_q + ONE_CNT;
        2'b01:   count_d = count_q - ONE_CNT;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous clear of pointers, count and storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= 32'h0000_0000;
        inst_q[i] <= 32'h0000_0000;
      end
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= ZERO_CNT;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue-based reference model checked every cycle
// plus directed scenarios with literal expectations. Honours FETCH_QUEUE_BYPASS_EN.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready, flush, stall;
  logic [31:0]   in_pc, in_inst, out_pc, out_inst;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  logic [63:0] mq[$];

  fetch_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .flush(flush), .stall(stall), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  function automatic bit model_bypass();
`ifdef FETCH_QUEUE_BYPASS_EN
    return (mq.size() == 0) && in_valid && out_ready && !flush && !stall;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: a plain queue of {pc, inst}
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      bit do_pop, do_push;
      do_pop  = (mq.size() != 0) && out_ready && !stall;
      do_push = in_valid && (mq.size() != DEPTH) && !model_bypass();
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({in_pc, in_inst});
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      bit exp_valid;
      logic [63:0] head;
      exp_valid = ((mq.size() != 0) && !flush && !stall) || model_bypass();
      head = (mq.size() != 0) ? mq[0] : {in_pc, in_inst};
      check("m_in_ready", {31'd0, in_ready}, {31'd0, (mq.size() != DEPTH) && !flush});
      check("m_out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      check("m_count", 32'(count), 32'(mq.size()));
      if (exp_valid) begin
        check("m_out_pc", out_pc, head[63:32]);
        check("m_out_inst", out_inst, head[31:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_inst  = inst_of(pc);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; stall = 1'b0;
    in_pc = 32'h0; in_inst = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);

    // Fill, hold a fifth push, then drain in order
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'(4 * k));
      step();
    end
    check("fill_count", 32'(count), 32'd4);
    check("fill_in_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'h10);
    step();
    check("held_count", 32'(count), 32'd4);
    drive(1'b0, 32'h0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_pc", out_pc, 32'(4 * k));
      step();
    end
    check("drain_empty", {31'd0, out_valid}, 32'd0);

    // Streaming across pointer wrap
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k));
      step();
`ifdef FETCH_QUEUE_BYPASS_EN
      check("stream_count", 32'(count), 32'd0);
`else
      check("stream_count", 32'(count), 32'd1);
`endif
    end
    drive(1'b0, 32'h0);
    step();
    check("stream_end", 32'(count), 32'd0);

    // Flush with three entries and a concurrent fetch
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h300 + 32'(4 * k));
      step();
    end
    drive(1'b1, 32'h200);
    flush = 1'b1;
    #1;
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    #1;
    check("flush_count", 32'(count), 32'd0);
    out_ready = 1'b1;
    step();
    check("flush_no_0x200", {31'd0, out_valid}, 32'd0);

    // Stall blocks pops while pushes continue
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h400 + 32'(4 * k));
      step();
    end
    stall = 1'b1;
    out_ready = 1'b1;
    for (int k = 2; k < 4; k++) begin
      drive(1'b1, 32'h400 + 32'(4 * k));
      step();
    end
    drive(1'b0, 32'h0);
    #1;
    check("stall_count", 32'(count), 32'd4);
    check("stall_out_valid", {31'd0, out_valid}, 32'd0);
    stall = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("stall_drain_pc", out_pc, 32'h400 + 32'(4 * k));
      step();
    end

    // Full queue popping still refuses input that cycle
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h500 + 32'(4 * k));
      step();
    end
    drive(1'b1, 32'h600);
    out_ready = 1'b1;
    #1;
    check("full_pop_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    drive(1'b0, 32'h0);
    out_ready = 1'b0;
    #1;
    check("full_pop_count", 32'(count), 32'd3);
    check("full_pop_in_ready_next", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (4) step();
    check("full_pop_drained", 32'(count), 32'd0);

    // Empty-queue latency (bypass or one cycle)
    drive(1'b1, 32'h40);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check("byp_out_valid", {31'd0, out_valid}, 32'd1);
    check("byp_out_pc", out_pc, 32'h40);
    step();
    drive(1'b0, 32'h0);
    #1;
    check("byp_count", 32'(count), 32'd0);
`else
    check("lat_out_valid0", {31'd0, out_valid}, 32'd0);
    step();
    drive(1'b0, 32'h0);
    #1;
    check("lat_out_valid1", {31'd0, out_valid}, 32'd1);
    check("lat_out_pc", out_pc, 32'h40);
    step();
`endif

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h700 + 32'(4 * k));
      step();
    end
    drive(1'b0, 32'h0);
    rst = 1'b1;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_out_pc", out_pc, 32'd0);
    step();
    rst = 1'b0;
    drive(1'b1, 32'h800);
    step();
    drive(1'b0, 32'h0);
    #1;
    check("arst_first_push", 32'(count), 32'd1);
    check("arst_first_pc", out_pc, 32'h800);
    out_ready = 1'b1;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling FIFO between the fetch stage and the decode/rename stage. It buffers up to DEPTH fetched {pc, inst} pairs, so an IM fetch that returns while decode is back-pressured (ROB, LQ/SQ or issue queue full) is kept rather than re-fetched. It discards its whole contents on a mispredict flush and withholds output while the ROB recovery stall is active.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, minimum 2.
- CW, $clog2(DEPTH+1): width of the `count` output.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch stage presents a pair.
- in_ready  out  1  queue accepts the pair.
- in_pc  in  32  PC of the fetched instruction.
- in_inst  in  32  instruction word.
- out_valid  out  1  queue presents a pair to decode.
- out_ready  in  1  decode consumes the pair.
- out_pc  out  32  head PC.
- out_inst  out  32  head instruction.
- flush  in  1  mispredict; discard all entries.
- stall  in  1  recovery stall; hold output.
- count  out  CW  registered occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH-entry register array; head and tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH; `count` register.
- push = in_valid & in_ready.
- pop = out_valid & out_ready & queue non-empty. A bypassed transfer is not a pop.
- in_ready = (count != DEPTH) & !flush. A full queue never accepts, even if it pops in the same cycle.
- out_valid = (count != 0) & !flush & !stall, plus the bypass term when enabled.
- out_pc / out_inst = head entry, combinationally from storage. When the queue is empty and not bypassing, they show the stale head entry; consumers must qualify with out_valid.
- Push writes the entry at tail, then tail+1. Pop advances head by 1.
- count update: push without pop +1; pop without push -1; push with pop, or neither, unchanged.
- Flush, on the clock edge: head = tail = count = 0. Any same-cycle in_valid is dropped, because in_ready is 0. Stored data is not cleared.
- Flush dominates stall and push. Stall blocks pop only; pushes continue while stalled.
- Reset: head, tail and count are 0, and all storage is 0. Resulting outputs: in_ready 1, out_valid 0, out_pc 0, out_inst 0, count 0.

## Timing
- Without bypass, latency is 1 cycle: a pair pushed at edge N is visible on out_* at edge N and poppable in cycle N+1.
- Throughput is 1 pair per cycle with a simultaneous push and pop at any occupancy below DEPTH.
- Full (count==DEPTH): in_ready is 0 for that whole cycle. If a pop occurs, in_ready is 1 in the next cycle.
- Empty (count==0): out_valid is 0 unless bypassing.
- Wrap-around: pointers roll DEPTH-1 → 0 with no bubble.
- Reset asserted mid-operation clears everything immediately and asynchronously. The first push is possible in the first cycle after deassertion.
- The flush is honoured in the same cycle it is asserted: out_valid and in_ready are 0 combinationally. The queue is empty from the next cycle.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When count==0, in_valid=1, out_ready=1, flush=0 and stall=0, out_valid=1 and out_pc/out_inst = in_pc/in_inst combinationally.
  - The pair is not written, and count and the pointers are unchanged.
  - This gives 0-cycle latency on an empty queue.
- FETCH_QUEUE_BYPASS_EN undefined: no combinational in→out path; minimum latency is 1 cycle.

## Test plan
- Reset then fill: push pcs 0x0,0x4,0x8,0xC with out_ready=0 → count 4, in_ready 0. A 5th push is held. Then out_ready=1 pops 0x0,0x4,0x8,0xC in order over 4 cycles.
- Streaming wrap: in_valid and out_ready both held high for 10 cycles with pcs 0x100+4k → output order is preserved across pointer wrap and count stays constant. Without bypass, count holds at 1 after the first cycle.
- Flush with count=3 while in_valid=1 (pc 0x200) → in_ready=0 and out_valid=0 that cycle. Next cycle count=0 and 0x200 never appears.
- Stall with count=2 and out_ready=1 → out_valid=0, no pops, pushes continue to count 4. Deassert stall → entries drain in order.
- Full with pop in the same cycle → in_ready stays 0 that cycle. Next cycle count=3 and in_ready=1.
- With FETCH_QUEUE_BYPASS_EN, empty queue, push pc 0x40 with out_ready=1 → out_valid=1 and out_pc=0x40 in the same cycle, count stays 0. Without the macro, out_valid=0 that cycle, then out_pc=0x40 with out_valid=1 in the next cycle.
